pulse_capture: RTL and testbench
================================

PULSE_CAPTURE -- requirements
Module: pulse_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 6: bit width of the measured pulse width, matching the 6-bit timer compare value.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port din  input  1: pulse to be measured (e.g. a timer Q output).
REQ-005 SHALL have port width  output  WIDTH: high time of the last completed pulse, in clk cycles; registered.
REQ-006 SHALL have port sat  output  1: the reported width saturated at 2^WIDTH-1; qualified by valid.
REQ-007 SHALL have port valid  output  1: width and sat hold a result not yet accepted.
REQ-008 SHALL have port ready  input  1: consumer accepts the result when valid and ready are both 1 at a clock edge.
REQ-009 SHALL have port overrun  output  1: a completed pulse was dropped because the previous result was still pending.

Function
REQ-010 SHALL define the sampled input s as din, or the synchronizer output when PULSE_CAPTURE_SYNC_EN is defined.
REQ-011 SHALL register the previous sample s_d. A rising edge is s=1 with s_d=0.
REQ-012 SHALL implement FSM states IDLE and COUNT.
REQ-013 SHALL transition IDLE->COUNT on a rising edge and load cnt=1.
REQ-014 SHALL, while in COUNT with s=1, increment cnt by 1 per cycle, saturating at 2^WIDTH-1.
REQ-015 SHALL set an internal sat_flag when an increment is blocked by saturation.
REQ-016 SHALL, in COUNT with s=0 (completion), return to IDLE.
REQ-017 SHALL give width=N for a pulse sampled high on exactly N consecutive edges, for N < 2^WIDTH.
REQ-018 SHALL give width=2^WIDTH-1 and sat=1 for a pulse with N >= 2^WIDTH.
REQ-019 SHALL, on completion with valid=0, or with valid=1 and ready=1, load width<=cnt and sat<=sat_flag, and set valid=1 at that same edge.
REQ-020 SHALL, on completion with valid=1 and ready=0, retain the old result, drop the new one, and set overrun=1.
REQ-021 SHALL clear valid on an accept edge with no completion in the same cycle.
REQ-022 SHALL keep overrun set until the next accept edge, which clears it. A new overrun at that same edge takes priority, leaving overrun=1.
REQ-023 SHALL report a 1-cycle gap between pulses as two separate pulses.
REQ-024 SHALL report valid=1 at the edge following din's fall (direct path), i.e. one cycle after the last high sample.

Reset
REQ-025 SHALL, on rst=1, immediately clear state=IDLE, cnt=0, sat_flag=0, width=0, sat=0, valid=0 and overrun=0, and set s_d=1. Synchronizer flops SHALL reset to 0.
REQ-026 SHALL abandon any pulse in progress when reset is asserted mid-pulse, with no result reported.
REQ-027 SHALL ignore a pulse already high at reset release (s_d=1 prevents a rising edge) until din has been low.

Configuration
REQ-028 SHALL, with PULSE_CAPTURE_SYNC_EN defined, pass din through a 2-flop synchronizer, adding exactly 2 cycles of latency to every event; widths are unchanged.
REQ-029 SHALL, without PULSE_CAPTURE_SYNC_EN, sample din directly and require din to be synchronous to clk.

Structure
REQ-030 SHALL define in package pulse_capture_pkg: the state encoding (IDLE, COUNT) and the default width constant (6).
REQ-031 SHALL place the synchronizer in one sub-module, pcap_sync2, instantiated only under PULSE_CAPTURE_SYNC_EN.

Verification (WIDTH=6, macro off unless noted)
REQ-032 SHALL verify: din high 4 cycles, ready=1 -> width=4, sat=0, valid=1 for 1 cycle, one cycle after din falls.
REQ-033 SHALL verify: din high 70 cycles -> width=63, sat=1.
REQ-034 SHALL verify: pulses of 3 then 5 cycles with ready=0 -> width stays 3, overrun=1; ready=1 for one cycle -> valid=0 and overrun=0 afterwards.
REQ-035 SHALL verify: pulses of 2 and 6 cycles separated by a 1-cycle low gap, ready=1 -> two results 2 then 6, overrun=0.
REQ-036 SHALL verify: rst pulsed during a 10-cycle pulse -> outputs 0 at once, no result for that pulse; the next clean 4-cycle pulse -> width=4.
REQ-037 SHALL verify: with PULSE_CAPTURE_SYNC_EN, a 4-cycle pulse -> width=4, with valid 2 cycles later than with the macro off.

Source files
------------

// File: rtl/pulse_capture_pkg.sv
// Shared definitions for the pulse width capture block: FSM encoding and default width.
package pulse_capture_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } pc_state_e;

  localparam int PC_WIDTH_DEF = 6;

endpackage

// File: rtl/pulse_capture_if.sv
// Result handshake between pulse_capture (master) and its consumer (slave).
interface pulse_capture_if
  import pulse_capture_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF
) ();

  logic [WIDTH-1:0] width;
  logic             sat;
  logic             valid;
  logic             ready;
  logic             overrun;

  modport master (output width, output sat, output valid, output overrun, input ready);
  modport slave  (input width, input sat, input valid, input overrun, output ready);

endinterface

// File: rtl/pcap_sync2.sv
// Two-flop synchronizer for an asynchronous pulse input; flops clear to 0 on reset.
module pcap_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronization chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pulse_capture.sv
// Measures the high time of din in clk cycles and hands results over a valid/ready port.
// Define PULSE_CAPTURE_SYNC_EN to route din through the pcap_sync2 synchronizer.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  pulse_capture_if.master res
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic             s_s;
  logic             rise_s;
  logic             done_s;
  logic             accept_s;
  logic             s_d_r;
  pc_state_e        state_r;
  logic [WIDTH-1:0] cnt_r;
  logic             sat_flag_r;
  logic [WIDTH-1:0] width_r;
  logic             sat_r;
  logic             valid_r;
  logic             overrun_r;

`ifdef PULSE_CAPTURE_SYNC_EN
  pcap_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (s_s)
  );
`else
  assign s_s = din;
`endif

  assign rise_s   = s_s & ~s_d_r;
  assign done_s   = (state_r == COUNT) & ~s_s;
  assign accept_s = valid_r & res.ready;

  // Edge detect, width counter FSM and result/overrun registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_r      <= 1'b1;
      state_r    <= IDLE;
      cnt_r      <= {WIDTH{1'b0}};
      sat_flag_r <= 1'b0;
      width_r    <= {WIDTH{1'b0}};
      sat_r      <= 1'b0;
      valid_r    <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      s_d_r <= s_s;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r    <= COUNT;
            cnt_r      <= CNT_ONE;
            sat_flag_r <= 1'b0;
          end
        end
        COUNT: begin
          if (s_s) begin
            if (cnt_r == CNT_MAX) begin
              sat_flag_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase

      // A completion either replaces an accepted/empty slot or is dropped as an overrun
      if (done_s && (!valid_r || res.ready)) begin
        width_r <= cnt_r;
        sat_r   <= sat_flag_r;
        valid_r <= 1'b1;
        if (accept_s) begin
          overrun_r <= 1'b0;
        end
      end else if (done_s) begin
        overrun_r <= 1'b1;
      end else if (accept_s) begin
        valid_r   <= 1'b0;
        overrun_r <= 1'b0;
      end
    end
  end

  assign res.width   = width_r;
  assign res.sat     = sat_r;
  assign res.valid   = valid_r;
  assign res.overrun = overrun_r;

endmodule

// File: tb/tb_pulse_capture.sv
// Scoreboard bench for pulse_capture: expected results queued per pulse, compared on delivery.
module tb_pulse_capture;

  typedef struct packed {
    logic [5:0] w;
    logic       s;
  } exp_t;

`ifdef PULSE_CAPTURE_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic pv;
  logic pr;

  pulse_capture_if #(.WIDTH(6)) pif ();

  pulse_capture #(.WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .res (pif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock; a freshly loaded result is popped from the scoreboard and compared
  task automatic tick();
    exp_t e;
    pv = pif.valid;
    pr = pif.ready;
    @(posedge clk);
    #1;
    if (pif.valid && (!pv || pr)) begin
      check_eq("result_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("width", 32'(pif.width), 32'(e.w));
        check_eq("sat", 32'(pif.sat), 32'(e.s));
      end
    end
  endtask

  task automatic pulse(input int n, input bit expect_result);
    exp_t e;
    din = 1'b1;
    repeat (n) tick();
    din = 1'b0;
    if (expect_result) begin
      e.w = (n >= 63) ? 6'd63 : 6'(n);
      e.s = (n >= 64) ? 1'b1 : 1'b0;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pif.ready = 1'b0;
    #1;
    check_eq("rst_width", 32'(pif.width), 32'd0);
    check_eq("rst_valid", 32'(pif.valid), 32'd0);
    check_eq("rst_sat", 32'(pif.sat), 32'd0);
    check_eq("rst_overrun", 32'(pif.overrun), 32'd0);
`ifndef PULSE_CAPTURE_SYNC_EN
    din = 1'b1;
`endif
    repeat (2) tick();
    rst = 1'b0;
    // din already high at reset release must not produce a result
    repeat (4) tick();
    din = 1'b0;
    repeat (4) tick();
    check_eq("held_high_ignored", 32'(pif.valid), 32'd0);

    // Basic 4-cycle pulse, latency and single-cycle valid
    pif.ready = 1'b1;
    pulse(4, 1'b1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pif.valid && n < 8);
    check_eq("latency", 32'(n), 32'(LAT));
    tick();
    check_eq("valid_1cyc", 32'(pif.valid), 32'd0);
    repeat (3) tick();

    // Boundaries: 1, 63, 64 and 70 cycles
    pulse(1, 1'b1);
    repeat (6) tick();
    pulse(63, 1'b1);
    repeat (6) tick();
    pulse(64, 1'b1);
    repeat (6) tick();
    pulse(70, 1'b1);
    repeat (6) tick();

    // Overrun: second result dropped while first is pending
    pif.ready = 1'b0;
    pulse(3, 1'b1);
    repeat (6) tick();
    pulse(5, 1'b0);
    repeat (6) tick();
    check_eq("ovr_width", 32'(pif.width), 32'd3);
    check_eq("ovr_flag", 32'(pif.overrun), 32'd1);
    check_eq("ovr_valid", 32'(pif.valid), 32'd1);
    pif.ready = 1'b1;
    tick();
    pif.ready = 1'b0;
    check_eq("ovr_clr_valid", 32'(pif.valid), 32'd0);
    check_eq("ovr_clr_flag", 32'(pif.overrun), 32'd0);
    repeat (2) tick();

    // Back-to-back pulses separated by a single low cycle
    pif.ready = 1'b1;
    pulse(2, 1'b1);
    tick();
    pulse(6, 1'b1);
    repeat (8) tick();
    check_eq("gap_overrun", 32'(pif.overrun), 32'd0);

    // Reset mid-pulse with a result pending
    pif.ready = 1'b0;
    pulse(3, 1'b1);
    repeat (6) tick();
    din = 1'b1;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(pif.valid), 32'd0);
    check_eq("mid_rst_width", 32'(pif.width), 32'd0);
    check_eq("mid_rst_overrun", 32'(pif.overrun), 32'd0);
`ifdef PULSE_CAPTURE_SYNC_EN
    din = 1'b0;
`endif
    repeat (2) tick();
    rst = 1'b0;
    pif.ready = 1'b1;
    repeat (3) tick();
    din = 1'b0;
    repeat (6) tick();
    check_eq("abandoned_pulse", 32'(pif.valid), 32'd0);
    pulse(4, 1'b1);
    repeat (8) tick();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
